// File: rtl/svc_rv_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// One-cycle registered lookup. An update in the same cycle as a lookup is not bypassed to that lookup.
module svc_rv_btb #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lookup_en,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_valid,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_uncond,
    input  logic [XLEN-1:0] upd_target,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_hits
);

    localparam int IW = $clog2(ENTRIES);
    localparam int TW = XLEN - IW - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic            pred_valid_d, pred_valid_q;
    logic            pred_taken_d, pred_taken_q;
    logic [XLEN-1:0] pred_target_d, pred_target_q;
    logic [31:0]     stat_lookups_d, stat_lookups_q;
    logic [31:0]     stat_hits_d, stat_hits_q;

    logic [IW-1:0] lk_idx, up_idx;
    logic [TW-1:0] lk_tag, up_tag;
    logic          rd_hit, up_hit;
    logic          wr_en, wr_tgt_en;
    logic [1:0]    wr_ctr, cur_ctr;
    logic          unused_pc_bits;

    assign lk_idx = lookup_pc[IW+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IW+2];
    assign up_idx = upd_pc[IW+1:2];
    assign up_tag = upd_pc[XLEN-1:IW+2];
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    // Update-side decision: what, if anything, gets written into the indexed entry.
    always_comb begin
        up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        cur_ctr   = ctr_q[up_idx];
        wr_en     = 1'b0;
        wr_tgt_en = 1'b0;
        wr_ctr    = cur_ctr;
        valid_d   = valid_q;
        if (upd_en && !rst) begin
            if (upd_uncond) begin
                wr_en     = 1'b1;
                wr_tgt_en = 1'b1;
                wr_ctr    = 2'd3;
            end else if (up_hit) begin
                wr_en     = 1'b1;
                wr_tgt_en = upd_taken;
                if (upd_taken) begin
                    wr_ctr = (cur_ctr == 2'd3) ? 2'd3 : cur_ctr + 2'd1;
                end else begin
                    wr_ctr = (cur_ctr == 2'd0) ? 2'd0 : cur_ctr - 2'd1;
                end
            end else if (upd_taken) begin
                wr_en     = 1'b1;
                wr_tgt_en = 1'b1;
                wr_ctr    = 2'd2;
            end else begin
                wr_en = 1'b0;
            end
        end else begin
            wr_en = 1'b0;
        end
        if (wr_en) begin
            valid_d[up_idx] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Lookup side: registered prediction and statistics; outputs hold while lookup_en is low.
    always_comb begin
        rd_hit         = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_valid_d   = pred_valid_q;
        pred_taken_d   = pred_taken_q;
        pred_target_d  = pred_target_q;
        stat_lookups_d = stat_lookups_q;
        stat_hits_d    = stat_hits_q;
        if (rst) begin
            pred_valid_d   = 1'b0;
            pred_taken_d   = 1'b0;
            pred_target_d  = '0;
            stat_lookups_d = 32'd0;
            stat_hits_d    = 32'd0;
        end else if (lookup_en) begin
            pred_valid_d   = rd_hit;
            pred_taken_d   = rd_hit && ctr_q[lk_idx][1];
            pred_target_d  = rd_hit ? target_q[lk_idx] : '0;
            stat_lookups_d = stat_lookups_q + 32'd1;
            stat_hits_d    = stat_hits_q + {31'd0, rd_hit};
        end else begin
            pred_valid_d = pred_valid_q;
        end
    end

    // Control state: valid bits, prediction outputs, statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            pred_valid_q   <= 1'b0;
            pred_taken_q   <= 1'b0;
            pred_target_q  <= '0;
            stat_lookups_q <= 32'd0;
            stat_hits_q    <= 32'd0;
        end else begin
            valid_q        <= valid_d;
            pred_valid_q   <= pred_valid_d;
            pred_taken_q   <= pred_taken_d;
            pred_target_q  <= pred_target_d;
            stat_lookups_q <= stat_lookups_d;
            stat_hits_q    <= stat_hits_d;
        end
    end

    // Entry payload arrays; left unreset because the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[up_idx] <= up_tag;
            ctr_q[up_idx] <= wr_ctr;
            if (wr_tgt_en) begin
                target_q[up_idx] <= upd_target;
            end
        end
    end

    assign pred_valid   = pred_valid_q;
    assign pred_taken   = pred_taken_q;
    assign pred_target  = pred_target_q;
    assign stat_lookups = stat_lookups_q;
    assign stat_hits    = stat_hits_q;

endmodule

// File: tb/tb_svc_rv_btb.sv
// Directed bench for svc_rv_btb: stimulus pushes expected per-cycle outputs into a queue,
// a negedge monitor pops and compares them.
module tb_svc_rv_btb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lookup_en = 1'b0;
    logic [31:0] lookup_pc = 32'd0;
    logic        pred_valid, pred_taken;
    logic [31:0] pred_target;
    logic        upd_en = 1'b0;
    logic [31:0] upd_pc = 32'd0;
    logic        upd_taken = 1'b0;
    logic        upd_uncond = 1'b0;
    logic [31:0] upd_target = 32'd0;
    logic [31:0] stat_lookups, stat_hits;

    svc_rv_btb #(.ENTRIES(16), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_uncond(upd_uncond), .upd_target(upd_target),
        .stat_lookups(stat_lookups), .stat_hits(stat_hits)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic        v;
        logic        t;
        logic [31:0] tg;
        logic [31:0] lk;
        logic [31:0] hit;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc_no = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic        last_v = 1'b0, last_t = 1'b0;
    logic [31:0] last_tg = 32'd0;
    logic [31:0] m_lk = 32'd0, m_hit = 32'd0;

    always @(posedge clk) cyc_no <= cyc_no + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total_cnt++;
        if (act !== expv) begin
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc_no, act, expv);
        end else begin
            pass_cnt++;
        end
    endtask

    // Monitor: compare the expectation queued for the edge just taken.
    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc_no) begin
            e = exp_q.pop_front();
            chk("stale_expectation", 32'(e.cyc), 32'(cyc_no));
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc_no) begin
            e = exp_q.pop_front();
            chk("pred_valid", {31'd0, pred_valid}, {31'd0, e.v});
            chk("pred_taken", {31'd0, pred_taken}, {31'd0, e.t});
            chk("pred_target", pred_target, e.tg);
            chk("stat_lookups", stat_lookups, e.lk);
            chk("stat_hits", stat_hits, e.hit);
        end
    end

    task automatic step(input logic r, input logic le, input logic [31:0] lpc,
                        input logic ue, input logic [31:0] upc, input logic ut,
                        input logic uu, input logic [31:0] utg,
                        input logic ev, input logic et, input logic [31:0] etg);
        exp_t e;
        rst = r; lookup_en = le; lookup_pc = lpc;
        upd_en = ue; upd_pc = upc; upd_taken = ut; upd_uncond = uu; upd_target = utg;
        if (r) begin
            last_v = 1'b0; last_t = 1'b0; last_tg = 32'd0;
            m_lk = 32'd0; m_hit = 32'd0;
        end else if (le) begin
            last_v = ev; last_t = et; last_tg = etg;
            m_lk = m_lk + 32'd1;
            if (ev) m_hit = m_hit + 32'd1;
        end
        e.cyc = cyc_no + 1; e.v = last_v; e.t = last_t; e.tg = last_tg;
        e.lk = m_lk; e.hit = m_hit;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic lk(input logic [31:0] pc, input logic ev, input logic et, input logic [31:0] etg);
        step(1'b0, 1'b1, pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, ev, et, etg);
    endtask

    task automatic up(input logic [31:0] pc, input logic t, input logic u, input logic [31:0] tg);
        step(1'b0, 1'b0, 32'd0, 1'b1, pc, t, u, tg, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        step(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'd0);
        lk(32'h100, 1'b0, 1'b0, 32'h0);

        // Counter walk on 0x100: allocate WT, down to SN, saturate, back up to ST
        up(32'h100, 1'b1, 1'b0, 32'h80);
        lk(32'h100, 1'b1, 1'b1, 32'h80);
        up(32'h100, 1'b0, 1'b0, 32'hFFF);
        up(32'h100, 1'b0, 1'b0, 32'hFFF);
        lk(32'h100, 1'b1, 1'b0, 32'h80);
        up(32'h100, 1'b0, 1'b0, 32'h0);
        lk(32'h100, 1'b1, 1'b0, 32'h80);
        up(32'h100, 1'b1, 1'b0, 32'h80);
        lk(32'h100, 1'b1, 1'b0, 32'h80);
        up(32'h100, 1'b1, 1'b0, 32'h80);
        lk(32'h100, 1'b1, 1'b1, 32'h80);
        up(32'h100, 1'b1, 1'b0, 32'h80);
        up(32'h100, 1'b1, 1'b0, 32'h88);
        up(32'h100, 1'b0, 1'b0, 32'h0);
        lk(32'h100, 1'b1, 1'b1, 32'h88);

        // JAL (uncond overrides taken=0) then replacement by same-index new tag
        up(32'h100, 1'b0, 1'b1, 32'h200);
        up(32'h100, 1'b0, 1'b0, 32'h0);
        lk(32'h100, 1'b1, 1'b1, 32'h200);
        up(32'h140, 1'b1, 1'b0, 32'h300);
        lk(32'h100, 1'b0, 1'b0, 32'h0);
        lk(32'h140, 1'b1, 1'b1, 32'h300);

        // Same-cycle lookup and first allocation: no bypass
        step(1'b0, 1'b1, 32'h208, 1'b1, 32'h208, 1'b1, 1'b0, 32'h400, 1'b0, 1'b0, 32'h0);
        lk(32'h208, 1'b1, 1'b1, 32'h400);

        // Not-taken miss does not allocate; stalled lookups hold outputs
        up(32'h104, 1'b0, 1'b0, 32'h600);
        lk(32'h104, 1'b0, 1'b0, 32'h0);
        lk(32'h140, 1'b1, 1'b1, 32'h300);
        up(32'h140, 1'b0, 1'b1, 32'h500);
        step(1'b0, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        lk(32'h143, 1'b1, 1'b1, 32'h500);

        // Populate four entries, reset during an update, everything misses afterwards
        up(32'h300, 1'b0, 1'b1, 32'hA00);
        up(32'h304, 1'b0, 1'b1, 32'hA04);
        up(32'h308, 1'b0, 1'b1, 32'hA08);
        up(32'h30C, 1'b0, 1'b1, 32'hA0C);
        lk(32'h308, 1'b1, 1'b1, 32'hA08);
        step(1'b1, 1'b1, 32'h304, 1'b1, 32'h310, 1'b1, 1'b0, 32'hB00, 1'b0, 1'b0, 32'h0);
        lk(32'h300, 1'b0, 1'b0, 32'h0);
        lk(32'h304, 1'b0, 1'b0, 32'h0);
        lk(32'h308, 1'b0, 1'b0, 32'h0);
        lk(32'h30C, 1'b0, 1'b0, 32'h0);
        lk(32'h310, 1'b0, 1'b0, 32'h0);

        lookup_en = 1'b0; upd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
